dma_dev_agent: RTL

// - Device-side end of the DMA device interface: issues rqst/start_addr/num_words/rd_wr to dma_controller, drives dev_ack, sources/sinks words.
// - Local FIFO decouples peripheral logic (host port) from the dev_ack/dma_ack handshake.
// - Write (rd_wr=0, device->memory): pops FIFO onto dev_out. Read (rd_wr=1, memory->device): pushes dev_in into FIFO.

---
 rtl/dma_dev_agent_if.sv | 26 ++
 rtl/dma_dev_agent.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_dev_agent_if.sv
// rtl/dma_dev_agent_if.sv - DMA device-side handshake bundle between dma_dev_agent and dma_controller
interface dma_dev_agent_if #(
  parameter int ADD_LEN  = 16,
  parameter int DATA_LEN = 16
);
  logic                rqst;
  logic                rd_wr;
  logic [ADD_LEN:0]    start_addr;
  logic [ADD_LEN-1:0]  num_words;
  logic                dev_ack;
  logic [DATA_LEN-1:0] dev_out;
  logic                dma_ack;
  logic [DATA_LEN-1:0] dev_in;
  logic                end_flag;
  logic                error_flag;

  modport master (
    output rqst, rd_wr, start_addr, num_words, dev_ack, dev_out,
    input  dma_ack, dev_in, end_flag, error_flag
  );

  modport slave (
    input  rqst, rd_wr, start_addr, num_words, dev_ack, dev_out,
    output dma_ack, dev_in, end_flag, error_flag
  );
endinterface

// File: rtl/dma_dev_agent.sv
// rtl/dma_dev_agent.sv - device-side DMA agent with local FIFO; DMA_DEV_TIMEOUT_EN enables the transfer watchdog
module dma_dev_agent #(
  parameter int ADD_LEN        = 16,
  parameter int DATA_LEN       = 16,
  parameter int BUF_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_start_i,
  input  logic                cmd_rd_wr_i,
  input  logic [ADD_LEN:0]    cmd_addr_i,
  input  logic [ADD_LEN-1:0]  cmd_words_i,
  input  logic                buf_wr_en_i,
  input  logic [DATA_LEN-1:0] buf_wr_data_i,
  input  logic                buf_rd_en_i,
  output logic [DATA_LEN-1:0] buf_rd_data_o,
  output logic                buf_full_o,
  output logic                buf_empty_o,
  input  logic                stall_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  dma_dev_agent_if.master     dma
);

  localparam int DEPTH = 1 << BUF_DEPTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_XFER     = 3'd2;
  localparam logic [2:0] S_WAIT_END = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_DMA_ERR  = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_REJECT   = 2'b11;

  logic [2:0]          state_q, state_d;
  logic                req_cnt_q, req_cnt_d;
  logic [ADD_LEN-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic                mism_q, mism_d;
  logic [1:0]          status_q, status_d;
  logic                rd_wr_q;
  logic [ADD_LEN:0]    addr_q;
  logic [ADD_LEN-1:0]  words_q;

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [BUF_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_DEPTH:0]   count_q;

  logic                fifo_empty, fifo_full;
  logic                xfer_wr, xfer_rd, cnt_done;
  logic                dma_push, dma_pop, host_push, host_pop;
  logic                push, pop;
  logic [DATA_LEN-1:0] push_data, head;
  logic [ADD_LEN-1:0]  cnt_inc;
  logic                reject;
  logic                timeout_hit;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (BUF_DEPTH+1)'(DEPTH));
  assign head       = mem[rd_ptr_q];

  assign xfer_wr  = (state_q == S_XFER) && !rd_wr_q;
  assign xfer_rd  = (state_q == S_XFER) &&  rd_wr_q;
  assign cnt_done = (xfer_cnt_q == words_q);
  assign cnt_inc  = (&xfer_cnt_q) ? xfer_cnt_q : xfer_cnt_q + ADD_LEN'(1);

  // A dma_ack against an empty/full FIFO moves no data; it only flags the mismatch.
  assign dma_pop   = xfer_wr && dma.dma_ack && !fifo_empty;
  assign dma_push  = xfer_rd && dma.dma_ack && !fifo_full;
  assign host_push = buf_wr_en_i && !fifo_full && !xfer_rd;
  assign host_pop  = buf_rd_en_i && !fifo_empty && !xfer_wr;
  assign push      = dma_push || host_push;
  assign pop       = dma_pop || host_pop;
  assign push_data = xfer_rd ? dma.dev_in : buf_wr_data_i;

  assign reject = (cmd_words_i == '0) ||
                  (!cmd_rd_wr_i && (ADD_LEN'(count_q) < cmd_words_i));

`ifdef DMA_DEV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_active;

  assign wd_active   = (state_q == S_XFER) || (state_q == S_WAIT_END) || (state_q == S_ERR);
  assign timeout_hit = wd_active && !dma.dma_ack && !dma.end_flag &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !wd_active || dma.dma_ack || dma.end_flag) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  // Watchdog compiled out: the agent waits for end_flag indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    mism_d     = mism_q;
    status_d   = status_q;

    if ((state_q == S_XFER) && dma.dma_ack) begin
      xfer_cnt_d = cnt_inc;
      if (rd_wr_q ? fifo_full : fifo_empty) begin
        mism_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          xfer_cnt_d = '0;
          mism_d     = 1'b0;
          req_cnt_d  = 1'b0;
          if (reject) begin
            state_d  = S_DONE;
            status_d = ST_REJECT;
          end else begin
            state_d  = S_REQ;
            status_d = ST_OK;
          end
        end
      end
      S_REQ: begin
        if (dma.error_flag) begin
          state_d = dma.end_flag ? S_DONE : S_ERR;
          if (dma.end_flag) status_d = ST_DMA_ERR;
        end else if (req_cnt_q) begin
          state_d = S_XFER;
        end else begin
          req_cnt_d = 1'b1;
        end
      end
      S_XFER, S_WAIT_END: begin
        if (dma.error_flag) begin
          state_d = dma.end_flag ? S_DONE : S_ERR;
          if (dma.end_flag) status_d = ST_DMA_ERR;
        end else if (dma.end_flag) begin
          state_d  = S_DONE;
          status_d = ((xfer_cnt_d != words_q) || mism_d) ? ST_MISMATCH : ST_OK;
        end else if (timeout_hit) begin
          state_d  = S_DONE;
          status_d = ST_REJECT;
        end else if ((state_q == S_XFER) && (xfer_cnt_d == words_q)) begin
          state_d = S_WAIT_END;
        end
      end
      S_ERR: begin
        if (dma.end_flag) begin
          state_d  = S_DONE;
          status_d = ST_DMA_ERR;
        end else if (timeout_hit) begin
          state_d  = S_DONE;
          status_d = ST_REJECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_cnt_q  <= 1'b0;
      xfer_cnt_q <= '0;
      mism_q     <= 1'b0;
      status_q   <= ST_OK;
      rd_wr_q    <= 1'b0;
      addr_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      mism_q     <= mism_d;
      status_q   <= status_d;
      if ((state_q == S_IDLE) && cmd_start_i) begin
        rd_wr_q <= cmd_rd_wr_i;
        addr_q  <= cmd_addr_i;
        words_q <= cmd_words_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + BUF_DEPTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + BUF_DEPTH'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (BUF_DEPTH+1)'(1);
        2'b01:   count_q <= count_q - (BUF_DEPTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign buf_rd_data_o = fifo_empty ? '0 : head;
  assign buf_full_o    = fifo_full;
  assign buf_empty_o   = fifo_empty;
  assign busy_o        = (state_q == S_REQ) || (state_q == S_XFER) ||
                         (state_q == S_WAIT_END) || (state_q == S_ERR);
  assign done_o        = (state_q == S_DONE);
  assign status_o      = status_q;

  assign dma.rqst       = (state_q == S_REQ);
  assign dma.rd_wr      = rd_wr_q;
  assign dma.start_addr = addr_q;
  assign dma.num_words  = words_q;
  assign dma.dev_ack    = xfer_wr ? (!stall_i && !fifo_empty && !cnt_done) :
                          xfer_rd ? (!stall_i && !fifo_full  && !cnt_done) : 1'b0;
  assign dma.dev_out    = (xfer_wr && !fifo_empty) ? head : '0;

endmodule
